// File: rtl/full_adder_primitive.sv
// Gate-level one-bit full adder with a clocked observation stage (registered result,
// saturating carry-event counter). Optional arithmetic self-check: FULL_ADDER_SELFCHECK_EN.
module full_adder_primitive #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             s,
  output logic             cout,
  input  logic             clk,
  input  logic             rst_n,
  output logic             s_q,
  output logic             cout_q,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             err
);

  logic ab_x;
  logic ab_and;
  logic bc_and;
  logic ac_and;

  // Primitive gates only, so X/Z propagate exactly as the gate library defines.
  xor u_xor_ab  (ab_x, a, b);
  xor u_xor_abc (s, ab_x, c);

  and u_and_ab (ab_and, a, b);
  and u_and_bc (bc_and, b, c);
  and u_and_ac (ac_and, a, c);
  or  u_or_maj (cout, ab_and, bc_and, ac_and);

  logic             s_d;
  logic             cout_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    s_d    = s;
    cout_d = cout;
    cnt_d  = cnt_q;
    // Saturate at all-ones rather than wrapping.
    if (cout && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= 1'b0;
      cout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign carry_cnt = cnt_q;

`ifdef FULL_ADDER_SELFCHECK_EN
  logic [1:0] ref_sum;
  logic       chk_known;
  logic       mismatch;
  logic       err_q;
  logic       err_d;

  always_comb begin
    ref_sum   = {1'b0, a} + {1'b0, b} + {1'b0, c};
    // Unknowns on either side are not treated as a mismatch.
    chk_known = !$isunknown({a, b, c, s, cout});
    mismatch  = chk_known && ({cout, s} != ref_sum);
    err_d     = err_q | mismatch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder_primitive.sv
// Directed bench for full_adder_primitive: truth table, latency, saturation, async reset,
// and the optional self-check flag.
module tb_full_adder_primitive;

  localparam int unsigned CntW = 3;

  logic            a = 1'b0;
  logic            b = 1'b0;
  logic            c = 1'b0;
  logic            s;
  logic            cout;
  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            s_q;
  logic            cout_q;
  logic [CntW-1:0] carry_cnt;
  logic            err;

  logic clk_en = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  full_adder_primitive #(
    .CNT_W(CntW)
  ) dut (
    .a        (a),
    .b        (b),
    .c        (c),
    .s        (s),
    .cout     (cout),
    .clk      (clk),
    .rst_n    (rst_n),
    .s_q      (s_q),
    .cout_q   (cout_q),
    .carry_cnt(carry_cnt),
    .err      (err)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    logic [2:0] abc;
    logic       s;
    logic       cout;
  } vec_t;

  vec_t tbl[8];

`ifdef FULL_ADDER_SELFCHECK_EN
  localparam logic ForcedErr = 1'b1;
`else
  localparam logic ForcedErr = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [2:0] v);
    {a, b, c} = v;
  endtask

  // Assert reset between edges, set inputs, release on the following falling edge.
  task automatic do_reset(input logic [2:0] v);
    @(negedge clk);
    rst_n = 1'b0;
    apply(v);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{3'b000, 1'b0, 1'b0};
    tbl[1] = '{3'b001, 1'b1, 1'b0};
    tbl[2] = '{3'b010, 1'b1, 1'b0};
    tbl[3] = '{3'b011, 1'b0, 1'b1};
    tbl[4] = '{3'b100, 1'b1, 1'b0};
    tbl[5] = '{3'b101, 1'b0, 1'b1};
    tbl[6] = '{3'b110, 1'b0, 1'b1};
    tbl[7] = '{3'b111, 1'b1, 1'b1};

    #1 rst_n = 1'b0;
    #1;
    check("reset s_q", 32'(s_q), 32'd0);
    check("reset cout_q", 32'(cout_q), 32'd0);
    check("reset carry_cnt", 32'(carry_cnt), 32'd0);
    check("reset err", 32'(err), 32'd0);

    // Combinational truth table with the clock stopped.
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].abc);
      #10;
      check($sformatf("tt s abc=%b", tbl[i].abc), 32'(s), 32'(tbl[i].s));
      check($sformatf("tt cout abc=%b", tbl[i].abc), 32'(cout), 32'(tbl[i].cout));
    end
    check("no clock s_q", 32'(s_q), 32'd0);

    // Registered latency.
    clk_en = 1'b1;
    do_reset(3'b000);
    @(negedge clk);
    apply(3'b101);
    #1;
    check("lat cout_q before edge", 32'(cout_q), 32'd0);
    @(posedge clk);
    #1;
    check("lat s_q after edge", 32'(s_q), 32'd0);
    check("lat cout_q after edge", 32'(cout_q), 32'd1);
    check("lat cnt after edge", 32'(carry_cnt), 32'd1);

    // Saturating counter.
    do_reset(3'b111);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("sat cnt edge %0d", i), 32'(carry_cnt), 32'(i < 7 ? i : 7));
    end
    check("sat s_q", 32'(s_q), 32'd1);
    @(negedge clk);
    apply(3'b001);
    repeat (2) @(posedge clk);
    #1;
    check("sat hold cnt", 32'(carry_cnt), 32'd7);
    check("001 s_q", 32'(s_q), 32'd1);
    check("001 cout_q", 32'(cout_q), 32'd0);

    // Asynchronous reset mid-run.
    do_reset(3'b011);
    repeat (5) @(posedge clk);
    #1;
    check("pre-reset cnt", 32'(carry_cnt), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("async s_q", 32'(s_q), 32'd0);
    check("async cout_q", 32'(cout_q), 32'd0);
    check("async cnt", 32'(carry_cnt), 32'd0);
    check("in reset s", 32'(s), 32'd0);
    check("in reset cout", 32'(cout), 32'd1);
    apply(3'b100);
    #1;
    check("in reset s track", 32'(s), 32'd1);
    check("in reset cout track", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    check("held reset cnt", 32'(carry_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(3'b011);
    repeat (2) @(posedge clk);
    #1;
    check("post-reset cnt", 32'(carry_cnt), 32'd2);

    // Self-check: clean sweep, then one corrupted sample.
    do_reset(3'b000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      apply(tbl[i].abc);
    end
    @(posedge clk);
    #1;
    check("sweep err", 32'(err), 32'd0);
    @(negedge clk);
    apply(3'b000);
    force dut.s = 1'b1;
    #1;
    check("forced err before edge", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    release dut.s;
    check("forced err after edge", 32'(err), 32'(ForcedErr));
    repeat (3) @(posedge clk);
    #1;
    check("err sticky", 32'(err), 32'(ForcedErr));
    #2 rst_n = 1'b0;
    #1;
    check("err cleared by reset", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/full_adder_primitive.md
# full_adder_primitive

- One-bit full adder built from gate primitives: XOR/AND/OR instances, no behavioural `+`.
- Drives combinational sum and carry-out.
- Adds a clocked observation stage: registered copies of the result, a saturating carry-event counter, and an optional self-check against an arithmetic reference.
- Serves as the leaf cell of ripple-carry adders and as a known-good gate-level reference in bring-up benches.

## Interface

Parameters:
- `CNT_W`, default 8: width of the carry-event counter; legal range 1..32.

Ports (clock and reset first). Declaration order is `a, b, c, s, cout, clk, rst_n, s_q, cout_q, carry_cnt, err`, so legacy 5-port positional instantiations bind correctly.
- `clk` in 1: single clock; all registers on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `a` in 1: addend bit.
- `b` in 1: addend bit.
- `c` in 1: carry-in.
- `s` out 1: combinational sum.
- `cout` out 1: combinational carry-out.
- `s_q` out 1: `s` registered.
- `cout_q` out 1: `cout` registered.
- `carry_cnt` out `CNT_W`: saturating count of cycles in which `cout` was 1.
- `err` out 1: sticky self-check mismatch flag. Tied 0 when the self-check is compiled out.

## Operation

- Sum and carry use gate primitives only:
  - `s = a ^ b ^ c`: two XOR instances.
  - `cout = (a & b) | (b & c) | (a & c)`: three AND instances and one 3-input OR.
- `s` and `cout` have no dependency on `clk` or `rst_n`; they are valid even if the clock never toggles.
- X/Z on any input propagates per primitive semantics. No masking.
- Register stage, on each rising `clk` while `rst_n` = 1:
  - `s_q` <= `s`; `cout_q` <= `cout`.
  - If `cout` = 1 and `carry_cnt` < 2^CNT_W-1: `carry_cnt` increments by 1.
  - At all-ones, `carry_cnt` holds (saturates, never wraps).
- Reset, while `rst_n` = 0 (asynchronous, immediate):
  - `s_q` = 0, `cout_q` = 0, `carry_cnt` = 0, `err` = 0.
  - Combinational `s` and `cout` remain live.
- Reset mid-operation: registered state clears at once. The first capture is on the first rising edge after `rst_n` rises.

## Timing

- `s` and `cout`: zero-cycle combinational, gate delays only.
- `s_q` and `cout_q`: 1-cycle latency; they reflect the inputs sampled at the previous rising edge.
- `carry_cnt`: updates 1 cycle after a `cout` = 1 sample.
- `err`: asserts 1 cycle after the mismatching sample. Cleared only by reset.
- Inputs changing between edges affect only the combinational outputs. Registers see only the value present at the edge.
- Reset release:
  - `rst_n` rising coincident with a `clk` edge does not capture on that edge.
  - Capture starts at the next edge.

## Configuration

Macro `FULL_ADDER_SELFCHECK_EN`.

When defined:
- A behavioural reference `{ref_c, ref_s} = a + b + c` is computed.
- On each rising edge, if `{cout, s}` != `{ref_c, ref_s}` and neither side contains X/Z, `err` sets to 1 and holds until reset.

When not defined:
- The reference logic is absent.
- `err` is constant 0.

## Test plan

- Truth table, all 8 combinations of `a`,`b`,`c` at 10-unit steps, no clock:
  - 000->s0 c0; 001->s1 c0; 010->s1 c0; 011->s0 c1;
  - 100->s1 c0; 101->s0 c1; 110->s0 c1; 111->s1 c1.
- Registered latency:
  - Reset, then apply 101 before edge N.
  - Then `s_q`=0 and `cout_q`=1 after edge N, not before.
- Counter:
  - `CNT_W`=3, hold 111 for 10 cycles -> `carry_cnt` reaches 7 and stays 7.
  - Apply 001 -> `carry_cnt` stays 7.
- Async reset:
  - Mid-run with `carry_cnt`=5, drop `rst_n` between edges.
  - Registered outputs and `carry_cnt` go to 0 immediately; `s`/`cout` still track inputs.
  - Release, apply 011 for 2 edges -> `carry_cnt`=2.
- Self-check with the macro defined:
  - Exhaustive sweep -> `err` stays 0.
  - Force `s` to an inverted value for one edge -> `err`=1 one cycle later and stays 1 until `rst_n`=0.
- Without the macro: the same force leaves `err`=0.
